lcplc_sample_framer: RTL and testbench

Upstream framing stage for the LCPLC coder. It accepts an untagged stream of samples already ordered block by block, band by band and row by row inside each block. It emits the same samples on the coder's x port with the four position flags (row, slice, band, image) derived from run-time dimension counters. A two-entry skid buffer gives full throughput and a registered input_ready.

---
 rtl/lcplc_pkg.sv | 19 +
 rtl/axis_skid_buffer.sv | 65 ++++++
 rtl/lcplc_sample_framer.sv | 134 +++++++++++++
 tb/tb_lcplc_sample_framer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcplc_pkg.sv
// Shared types for the LCPLC coder front end: per-sample position flags and
// the framer FSM state encoding.
package lcplc_pkg;

    typedef struct packed {
        logic last_r;
        logic last_s;
        logic last_b;
        logic last_i;
    } lcplc_flags_t;

    localparam int FLAGS_W = $bits(lcplc_flags_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } framer_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered upstream ready.
// The output register is loaded directly when free, so there is no added bubble.
module axis_skid_buffer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_hs;
    logic             out_free;
    logic             out_valid_nxt;
    logic             skid_valid_nxt;

    assign in_hs    = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    always_comb begin
        out_valid_nxt  = out_valid;
        skid_valid_nxt = skid_valid;
        if (out_free) begin
            out_valid_nxt  = skid_valid || in_hs;
            skid_valid_nxt = skid_valid && in_hs;
        end else if (in_hs) begin
            skid_valid_nxt = 1'b1;
        end
    end

    // Ready is computed from next-state occupancy so it can be registered
    // without ever accepting into a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
            out_data   <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready   <= !(out_valid_nxt && skid_valid_nxt);
            if (out_free) begin
                if (skid_valid) begin
                    out_data <= skid_data;
                end else if (in_hs) begin
                    out_data <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs && (skid_valid || !out_free)) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/lcplc_sample_framer.sv
// Tags an ordered sample stream with row/slice/band/image end flags derived
// from run-time dimension counters, then buffers it for the coder's x port.
module lcplc_sample_framer
    import lcplc_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int MAX_SLICE_SIZE_LOG = 8,
    parameter int BAND_WIDTH         = 10,
    parameter int BLOCK_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [DATA_WIDTH-1:0]         input_data,
    output logic                          x_valid,
    input  logic                          x_ready,
    output logic [DATA_WIDTH-1:0]         x_data,
    output logic                          x_last_r,
    output logic                          x_last_s,
    output logic                          x_last_b,
    output logic                          x_last_i,
    input  logic [MAX_SLICE_SIZE_LOG-1:0] cfg_cols_m1,
    input  logic [MAX_SLICE_SIZE_LOG-1:0] cfg_rows_m1,
    input  logic [BAND_WIDTH-1:0]         cfg_bands_m1,
    input  logic [BLOCK_WIDTH-1:0]        cfg_blocks_m1,
    output logic                          busy
);

    localparam int WORD_W = DATA_WIDTH + FLAGS_W;

    framer_state_t                 state;
    logic [MAX_SLICE_SIZE_LOG-1:0] col, row;
    logic [BAND_WIDTH-1:0]         band;
    logic [BLOCK_WIDTH-1:0]        block;
    logic [MAX_SLICE_SIZE_LOG-1:0] sh_cols_m1, sh_rows_m1;
    logic [BAND_WIDTH-1:0]         sh_bands_m1;
    logic [BLOCK_WIDTH-1:0]        sh_blocks_m1;

    logic [MAX_SLICE_SIZE_LOG-1:0] eff_cols_m1, eff_rows_m1;
    logic [BAND_WIDTH-1:0]         eff_bands_m1;
    logic [BLOCK_WIDTH-1:0]        eff_blocks_m1;

    lcplc_flags_t      flags;
    lcplc_flags_t      x_flags;
    logic              in_hs;
    logic [WORD_W-1:0] x_word;

    assign in_hs = input_valid && input_ready;

    // The first sample of an image is framed against the live config.
    assign eff_cols_m1   = (state == ST_IDLE) ? cfg_cols_m1   : sh_cols_m1;
    assign eff_rows_m1   = (state == ST_IDLE) ? cfg_rows_m1   : sh_rows_m1;
    assign eff_bands_m1  = (state == ST_IDLE) ? cfg_bands_m1  : sh_bands_m1;
    assign eff_blocks_m1 = (state == ST_IDLE) ? cfg_blocks_m1 : sh_blocks_m1;

    always_comb begin
        flags        = '0;
        flags.last_r = (col == eff_cols_m1);
        flags.last_s = flags.last_r && (row == eff_rows_m1);
        flags.last_b = flags.last_s && (band == eff_bands_m1);
        flags.last_i = flags.last_b && (block == eff_blocks_m1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            col          <= '0;
            row          <= '0;
            band         <= '0;
            block        <= '0;
            sh_cols_m1   <= '0;
            sh_rows_m1   <= '0;
            sh_bands_m1  <= '0;
            sh_blocks_m1 <= '0;
        end else if (in_hs) begin
            if (flags.last_i) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                col   <= '0;
                row   <= '0;
                band  <= '0;
                block <= '0;
            end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
                if (state == ST_IDLE) begin
                    sh_cols_m1   <= cfg_cols_m1;
                    sh_rows_m1   <= cfg_rows_m1;
                    sh_bands_m1  <= cfg_bands_m1;
                    sh_blocks_m1 <= cfg_blocks_m1;
                end
                if (flags.last_r) begin
                    col <= '0;
                    if (flags.last_s) begin
                        row <= '0;
                        if (flags.last_b) begin
                            band  <= '0;
                            block <= block + BLOCK_WIDTH'(1);
                        end else begin
                            band <= band + BAND_WIDTH'(1);
                        end
                    end else begin
                        row <= row + MAX_SLICE_SIZE_LOG'(1);
                    end
                end else begin
                    col <= col + MAX_SLICE_SIZE_LOG'(1);
                end
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH(WORD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (input_valid),
        .in_ready (input_ready),
        .in_data  ({input_data, flags}),
        .out_valid(x_valid),
        .out_ready(x_ready),
        .out_data (x_word)
    );

    assign x_data   = x_word[WORD_W-1:FLAGS_W];
    assign x_flags  = x_word[FLAGS_W-1:0];
    assign x_last_r = x_flags.last_r;
    assign x_last_s = x_flags.last_s;
    assign x_last_b = x_flags.last_b;
    assign x_last_i = x_flags.last_i;

endmodule

// File: tb/tb_lcplc_sample_framer.sv
// Scoreboard bench for lcplc_sample_framer: a position-index reference model
// predicts each sample's flags; a monitor checks the x port against the queue.
module tb_lcplc_sample_framer;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    f;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [DW-1:0] input_data = '0;
    logic          x_valid;
    logic          x_ready = 1'b0;
    logic [DW-1:0] x_data;
    logic          x_last_r, x_last_s, x_last_b, x_last_i;
    logic [7:0]    cfg_cols_m1 = '0;
    logic [7:0]    cfg_rows_m1 = '0;
    logic [9:0]    cfg_bands_m1 = '0;
    logic [15:0]   cfg_blocks_m1 = '0;
    logic          busy;

    lcplc_sample_framer #(
        .DATA_WIDTH(DW), .MAX_SLICE_SIZE_LOG(8), .BAND_WIDTH(10), .BLOCK_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .x_last_r(x_last_r), .x_last_s(x_last_s), .x_last_b(x_last_b), .x_last_i(x_last_i),
        .cfg_cols_m1(cfg_cols_m1), .cfg_rows_m1(cfg_rows_m1),
        .cfg_bands_m1(cfg_bands_m1), .cfg_blocks_m1(cfg_blocks_m1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   xmode = 3;
    bit   in_reset = 1'b1;
    exp_t q[$];

    // Reference model: position index within the image plus dimensions latched at image start.
    int k = 0;
    int mc = 1, mr = 1, mb = 1, mk = 1;
    int seq_data = 0;
    bit seq_mode = 1'b0;

    int xfer_cnt = 0;
    int first_xfer_cyc = -1;
    int last_xfer_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        int col, row, band, total;
        exp_t e;
        if (k == 0) begin
            mc = int'(cfg_cols_m1) + 1;
            mr = int'(cfg_rows_m1) + 1;
            mb = int'(cfg_bands_m1) + 1;
            mk = int'(cfg_blocks_m1) + 1;
        end
        total = mc * mr * mb * mk;
        col   = k % mc;
        row   = (k / mc) % mr;
        band  = (k / (mc * mr)) % mb;
        e.d   = d;
        e.f[3] = (col == mc - 1);
        e.f[2] = e.f[3] && (row == mr - 1);
        e.f[1] = e.f[2] && (band == mb - 1);
        e.f[0] = (k == total - 1);
        q.push_back(e);
        k = e.f[0] ? 0 : k + 1;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (xmode)
            0:       x_ready = 1'b1;
            1:       x_ready = (cyc % 3 == 0);
            2:       x_ready = ($urandom_range(1) == 1);
            default: x_ready = 1'b0;
        endcase
    end

    // Occupancy, valid and busy must track the scoreboard after every edge.
    always @(posedge clk) begin
        #2;
        if (!in_reset) begin
            chk("input_ready", 32'(input_ready), 32'(q.size() < 2));
            chk("x_valid", 32'(x_valid), 32'(q.size() > 0));
            chk("busy", 32'(busy), 32'(k != 0));
        end
    end

    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic [3:0]    prev_flags;

    always @(negedge clk) begin
        exp_t e;
        if (in_reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(x_valid), 32'(1));
                chk("hold_data", 32'(x_data), 32'(prev_data));
                chk("hold_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'(prev_flags));
            end
            hold_prev  = x_valid && !x_ready;
            prev_data  = x_data;
            prev_flags = {x_last_r, x_last_s, x_last_b, x_last_i};
            if (x_valid && x_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got data %0h with empty scoreboard", x_data);
                end else begin
                    e = q.pop_front();
                    chk("x_data", 32'(x_data), 32'(e.d));
                    chk("x_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'(e.f));
                    xfer_cnt++;
                    if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                end
            end
        end
    end

    task automatic send(input int n, input bit gaps, output int stalls);
        bit acc;
        int guard;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    input_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            input_data  = seq_mode ? DW'(seq_data) : DW'($urandom);
            seq_data++;
            input_valid = 1'b1;
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = input_ready;
                if (acc) model_accept(input_data);
                else stalls++;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 200) begin
                    $display("FAIL send_timeout: got no acceptance after %0d cycles, required <= 200", guard);
                    $fatal(1);
                end
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 32'(0));
    endtask

    task automatic do_reset();
        xmode = 3;
        input_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_reset = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_x_valid", 32'(x_valid), 32'(0));
        chk("rst_input_ready", 32'(input_ready), 32'(0));
        chk("rst_x_data", 32'(x_data), 32'(0));
        chk("rst_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        q.delete();
        k = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(input_ready), 32'(1));
        in_reset = 1'b0;
    endtask

    task automatic set_cfg(input int c, input int r, input int b, input int bl);
        cfg_cols_m1   = 8'(c);
        cfg_rows_m1   = 8'(r);
        cfg_bands_m1  = 10'(b);
        cfg_blocks_m1 = 16'(bl);
    endtask

    initial begin
        int st;
        int x0;
        #2_000_000;
        $display("FAIL watchdog: got no finish by %0t, required end of run", $time);
        $fatal(1);
    end

    initial begin
        int st;
        int x0;
        do_reset();

        // Basic framing, samples 0..15, continuous ready.
        set_cfg(3, 1, 1, 0);
        seq_mode = 1'b1; seq_data = 0;
        xmode = 0;
        send(16, 1'b0, st);
        chk("t1_stalls", 32'(st), 32'(0));
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t1_busy_end", 32'(busy), 32'(0));

        // Single-sample images back to back.
        set_cfg(0, 0, 0, 0);
        send(3, 1'b0, st);
        chk("t2_no_bubble", 32'(st), 32'(0));
        drain();

        // Backpressure: ready one cycle in three.
        set_cfg(3, 1, 1, 0);
        seq_data = 0;
        xmode = 1;
        send(16, 1'b0, st);
        drain();

        // Config change mid-image is ignored until the image ends.
        seq_mode = 1'b0;
        xmode = 2;
        send(5, 1'b1, st);
        cfg_cols_m1 = 8'd1;
        send(11, 1'b1, st);
        send(8, 1'b1, st);
        drain();

        // Reset mid-stream with data held in the buffer.
        set_cfg(3, 1, 1, 0);
        xmode = 1;
        send(10, 1'b0, st);
        do_reset();
        xmode = 0;
        send(16, 1'b1, st);
        drain();

        // Maximum column count, two blocks, full throughput.
        set_cfg(255, 0, 0, 1);
        xmode = 0;
        repeat (2) @(posedge clk);
        #1;
        x0 = xfer_cnt;
        first_xfer_cyc = -1;
        send(512, 1'b0, st);
        chk("t6_stalls", 32'(st), 32'(0));
        drain();
        chk("t6_xfers", 32'(xfer_cnt - x0), 32'(512));
        chk("t6_span", 32'(last_xfer_cyc - first_xfer_cyc), 32'(511));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
